// File: rtl/program_loader_pkg.sv
// Shared definitions for the program loader: FSM encoding and word geometry.
package program_loader_pkg;

  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    WRITE   = 2'd2,
    DONE    = 2'd3
  } state_t;

endpackage : program_loader_pkg

// File: rtl/program_loader_word_assembler.sv
// Little-endian byte-to-word assembler: each loaded byte lands in the lane
// selected by lane; clear zeroes the whole word.
module word_assembler
  import program_loader_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            byte_in,
  input  logic [1:0]            lane,
  input  logic                  load,
  input  logic                  clear,
  output logic [DATA_WIDTH-1:0] word
);

  logic [4:0] lane_base;

  assign lane_base = {lane, 3'b000};

  // Word register: clear wins over load, otherwise one byte lane is replaced.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments in clocked blocks so every register
    // samples pre-edge values, independent of statement order.
    if (!rst_n) begin
      word <= '0;
    end else if (clear) begin
      word <= '0;
    end else if (load) begin
      word[lane_base +: 8] <= byte_in;
    end
  end

endmodule : word_assembler

// File: rtl/program_loader.sv
// Program loader: collects a byte stream into little-endian instruction words
// and strobes them into program memory at consecutive word addresses.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int MEMORY_DEPTH = 32,
  parameter int DATA_WIDTH   = 32
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        Start,
  input  logic [$clog2(MEMORY_DEPTH):0] Length,
  input  logic                        Abort,
  input  logic [7:0]                  ByteIn,
  input  logic                        ByteValid,
  output logic                        ByteReady,
  output logic [DATA_WIDTH-1:0]       Address,
  output logic [DATA_WIDTH-1:0]       WriteData,
  output logic                        MemWrite,
  output logic                        Busy,
  output logic                        Done,
  output logic                        Error
);

  localparam int LEN_W  = $clog2(MEMORY_DEPTH) + 1;
  // Just wide enough for 4*(MEMORY_DEPTH-1); upper Address bits stay zero.
  localparam int ADDR_W = $clog2(MEMORY_DEPTH) + 2;

  state_t            state, state_next;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  remaining_q;
  logic [1:0]        byte_cnt_q;
  logic              done_q;
  logic              error_q;

  logic idle_like;
  logic start_ok;
  logic byte_accept;
  logic last_byte;
  logic last_word;

  assign idle_like   = (state == IDLE) || (state == DONE);
  assign start_ok    = Start && (Length != '0) && (Length <= LEN_W'(MEMORY_DEPTH));
  // Abort outranks a coincident byte, so the byte is not taken.
  assign byte_accept = (state == COLLECT) && ByteValid && !Abort;
  assign last_byte   = (byte_cnt_q == 2'(BYTES_PER_WORD - 1));
  assign last_word   = (remaining_q == LEN_W'(1));

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode.
  always_comb begin
    // NOTE: default first so every path assigns state_next and no latch forms.
    state_next = state;
    case (state)
      IDLE, DONE: begin
        if (Start) state_next = start_ok ? COLLECT : IDLE;
      end
      COLLECT: begin
        if (Abort)                         state_next = IDLE;
        else if (byte_accept && last_byte) state_next = WRITE;
      end
      WRITE: begin
        if (Abort)          state_next = IDLE;
        else if (last_word) state_next = DONE;
        else                state_next = COLLECT;
      end
      default: state_next = IDLE;
    endcase
  end

  // Load bookkeeping: address, words remaining, byte lane and status flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q      <= '0;
      remaining_q <= '0;
      byte_cnt_q  <= '0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start_ok) begin
            addr_q      <= '0;
            remaining_q <= Length;
            byte_cnt_q  <= '0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
          end else if (Start) begin
            done_q  <= 1'b0;
            error_q <= 1'b1;
          end
        end
        COLLECT: begin
          if (Abort)            error_q    <= 1'b1;
          else if (byte_accept) byte_cnt_q <= byte_cnt_q + 2'd1;
        end
        WRITE: begin
          if (Abort) begin
            error_q <= 1'b1;
          end else begin
            byte_cnt_q  <= '0;
            remaining_q <= remaining_q - LEN_W'(1);
            // The address only advances when another word follows, so the
            // final value never passes the last written word.
            if (last_word) done_q <= 1'b1;
            else           addr_q <= addr_q + ADDR_W'(BYTES_PER_WORD);
          end
        end
        default: ;
      endcase
    end
  end

  word_assembler #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_word_assembler (
    .clk     (clk),
    .rst_n   (reset),
    .byte_in (ByteIn),
    .lane    (byte_cnt_q),
    .load    (byte_accept),
    .clear   (idle_like && start_ok),
    .word    (WriteData)
  );

  assign ByteReady = (state == COLLECT);
  assign Busy      = (state == COLLECT) || (state == WRITE);
  assign Done      = done_q;
  assign Error     = error_q;
  assign Address   = DATA_WIDTH'(addr_q);
  // Abort must suppress the strobe within the WRITE cycle itself, which
  // needs the one input term on this otherwise state-decoded output.
  assign MemWrite  = (state == WRITE) && !Abort;

endmodule : program_loader

// File: tb/tb_program_loader.sv
// Directed self-checking bench for program_loader.
module tb_program_loader;

  localparam int DEPTH = 32;

  logic        clk = 1'b0;
  logic        reset;
  logic        Start;
  logic [5:0]  Length;
  logic        Abort;
  logic [7:0]  ByteIn;
  logic        ByteValid;
  logic        ByteReady;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic        MemWrite;
  logic        Busy;
  logic        Done;
  logic        Error;

  int checks = 0;
  int errors = 0;

  logic [31:0] log_addr[$];
  logic [31:0] log_data[$];

  program_loader #(
    .MEMORY_DEPTH (DEPTH),
    .DATA_WIDTH   (32)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .Start     (Start),
    .Length    (Length),
    .Abort     (Abort),
    .ByteIn    (ByteIn),
    .ByteValid (ByteValid),
    .ByteReady (ByteReady),
    .Address   (Address),
    .WriteData (WriteData),
    .MemWrite  (MemWrite),
    .Busy      (Busy),
    .Done      (Done),
    .Error     (Error)
  );

  always #5 clk = ~clk;

  // Strobe monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (MemWrite) begin
      log_addr.push_back(Address);
      log_data.push_back(WriteData);
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the Start cycle.
  task automatic start_load(input logic [5:0] len);
    Start  = 1'b1;
    Length = len;
    @(posedge clk); #1;
    Start  = 1'b0;
  endtask

  // Offer one byte until taken (bounded); returns at posedge+1.
  task automatic send_byte(input logic [7:0] b, input int gap);
    logic got;
    got = 1'b0;
    repeat (gap) @(posedge clk);
    if (gap > 0) #1;
    ByteIn    = b;
    ByteValid = 1'b1;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (ByteReady) begin
        got = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
    ByteValid = 1'b0;
    check("byte_accepted", {63'd0, got}, 64'd1);
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], gap);
  endtask

  task automatic wait_done();
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (Done) break;
    end
    check("done_reached", {63'd0, Done}, 64'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    int base;
    int bad;
    logic [31:0] max_a;
    logic [31:0] w;
    logic [7:0]  i8;

    reset = 1'b0; Start = 1'b0; Length = '0; Abort = 1'b0;
    ByteIn = '0; ByteValid = 1'b0;
    #1;
    check("reset_outputs", {Address, WriteData}, 64'd0);
    check("reset_flags", {59'd0, MemWrite, ByteReady, Busy, Done, Error}, 64'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    // Nominal two-word load.
    base = log_addr.size();
    start_load(6'd2);
    @(negedge clk);
    check("nominal_busy_ready", {62'd0, Busy, ByteReady}, 64'd3);
    @(posedge clk); #1;
    send_word(32'h2008_0013, 0);
    send_word(32'h0000_0000, 0);
    wait_done();
    check("nominal_strobes", 64'(log_addr.size() - base), 64'd2);
    check("nominal_w0", {log_addr[base], log_data[base]}, {32'h0, 32'h2008_0013});
    check("nominal_w1", {log_addr[base+1], log_data[base+1]}, {32'h4, 32'h0});
    check("nominal_end_flags", {61'd0, Done, Busy, Error}, {61'd0, 3'b100});

    // Full-depth load: word i = {i, 5A, C3, ~i}.
    base = log_addr.size();
    start_load(6'd32);
    for (int i = 0; i < DEPTH; i++) begin
      i8 = 8'(i);
      send_word({i8, 8'h5A, 8'hC3, ~i8}, 0);
    end
    wait_done();
    check("full_strobes", 64'(log_addr.size() - base), 64'd32);
    check("full_first", {log_addr[base], log_data[base]}, {32'h0, 32'h005A_C3FF});
    check("full_last", {log_addr[base+31], log_data[base+31]}, {32'h7C, 32'h1F5A_C3E0});
    bad = 0;
    max_a = '0;
    for (int i = base; i < log_addr.size(); i++) begin
      i8 = 8'(i - base);
      w  = {i8, 8'h5A, 8'hC3, ~i8};
      if (log_addr[i] !== 32'(4 * (i - base)) || log_data[i] !== w) bad++;
      if (log_addr[i] > max_a) max_a = log_addr[i];
    end
    check("full_all_words", 64'(bad), 64'd0);
    check("full_max_addr", {32'd0, max_a}, 64'h7C);
    check("full_addr_bound", {63'd0, Address <= 32'h7C}, 64'd1);

    // Rejected requests.
    base = log_addr.size();
    start_load(6'd0);
    @(negedge clk);
    check("reject0_flags", {61'd0, Error, Done, Busy}, {61'd0, 3'b100});
    @(posedge clk); #1;
    start_load(6'd33);
    repeat (3) @(negedge clk);
    check("reject33_flags", {60'd0, Error, Done, Busy, ByteReady}, {60'd0, 4'b1000});
    check("reject_no_strobe", 64'(log_addr.size() - base), 64'd0);
    @(posedge clk); #1;

    // Stalled load: 5-cycle ByteValid gaps.
    base = log_addr.size();
    start_load(6'd2);
    send_byte(8'h13, 0);
    send_byte(8'h00, 0);
    repeat (3) @(negedge clk);
    check("stall_hold", {61'd0, ByteReady, Busy, MemWrite}, {61'd0, 3'b110});
    @(posedge clk); #1;
    send_byte(8'h08, 5);
    send_byte(8'h20, 5);
    send_word(32'h0000_0000, 5);
    wait_done();
    check("stall_strobes", 64'(log_addr.size() - base), 64'd2);
    check("stall_w0", {log_addr[base], log_data[base]}, {32'h0, 32'h2008_0013});
    check("stall_w1", {log_addr[base+1], log_data[base+1]}, {32'h4, 32'h0});

    // Abort after the 3rd byte of word 1.
    base = log_addr.size();
    start_load(6'd2);
    send_word(32'h1122_3344, 0);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    send_byte(8'hCC, 0);
    Abort = 1'b1;
    @(posedge clk); #1;
    Abort = 1'b0;
    ByteIn = 8'hDD; ByteValid = 1'b1;
    repeat (4) @(negedge clk);
    ByteValid = 1'b0;
    check("abort_flags", {60'd0, Error, Busy, ByteReady, Done}, {60'd0, 4'b1000});
    check("abort_strobes", 64'(log_addr.size() - base), 64'd1);
    check("abort_w0", {log_addr[base], log_data[base]}, {32'h0, 32'h1122_3344});
    @(posedge clk); #1;

    // Reset after the 6th byte, then reload one word.
    base = log_addr.size();
    start_load(6'd2);
    send_word(32'h5566_7788, 0);
    send_byte(8'h01, 0);
    send_byte(8'h02, 0);
    #2;
    reset = 1'b0;
    #1;
    check("midreset_data", {Address, WriteData}, 64'd0);
    check("midreset_flags", {59'd0, MemWrite, ByteReady, Busy, Done, Error}, 64'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check("midreset_strobes", 64'(log_addr.size() - base), 64'd1);
    base = log_addr.size();
    start_load(6'd1);
    send_word(32'hDEAD_BEEF, 0);
    wait_done();
    check("reload_strobes", 64'(log_addr.size() - base), 64'd1);
    check("reload_w0", {log_addr[base], log_data[base]}, {32'h0, 32'hDEAD_BEEF});

    // Start during COLLECT is ignored; original Length of 2 completes.
    base = log_addr.size();
    start_load(6'd2);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    start_load(6'd1);
    @(negedge clk);
    check("restart_ignored", {62'd0, Busy, ByteReady}, 64'd3);
    @(posedge clk); #1;
    send_byte(8'h33, 0);
    send_byte(8'h44, 0);
    send_word(32'h0BAD_F00D, 0);
    wait_done();
    check("restart_strobes", 64'(log_addr.size() - base), 64'd2);
    check("restart_w0", {log_addr[base], log_data[base]}, {32'h0, 32'h4433_2211});
    check("restart_w1", {log_addr[base+1], log_data[base+1]}, {32'h4, 32'h0BAD_F00D});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_program_loader

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 SHALL have parameter MEMORY_DEPTH, default 32, the number of instruction words in the target program memory.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, the instruction and address width; fixed at 4 bytes per word.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port Start, input, 1 bit: a one-cycle request to begin a load.
REQ-006 SHALL have port Length, input, clog2(MEMORY_DEPTH)+1 bits: the word count, sampled only when Start is accepted.
REQ-007 SHALL have port Abort, input, 1 bit: cancels a load in progress.
REQ-008 SHALL have port ByteIn, input, 8 bits: the incoming program byte.
REQ-009 SHALL have port ByteValid, input, 1 bit: ByteIn is valid.
REQ-010 SHALL have port ByteReady, output, 1 bit: the loader accepts a byte this cycle.
REQ-011 SHALL have port Address, output, DATA_WIDTH bits: the byte address of the word being written; always word-aligned.
REQ-012 SHALL have port WriteData, output, DATA_WIDTH bits: the assembled instruction word.
REQ-013 SHALL have port MemWrite, output, 1 bit: a one-cycle write strobe to program memory.
REQ-014 SHALL have port Busy, output, 1 bit: a load is in progress; the CPU is held.
REQ-015 SHALL have port Done, output, 1 bit: the last load completed; a level signal.
REQ-016 SHALL have port Error, output, 1 bit: the last request was rejected or aborted; a level signal.

Function
REQ-017 SHALL implement states IDLE, COLLECT, WRITE and DONE.
REQ-018 SHALL, in IDLE or DONE, on Start with 1 <= Length <= MEMORY_DEPTH, latch Length, set Address=0, byte count=0, WriteData=0, clear Done and Error, and enter COLLECT next cycle.
REQ-019 SHALL, on Start with Length==0 or Length>MEMORY_DEPTH, set Error=1, clear Done, go to IDLE, and write nothing.
REQ-020 SHALL ignore Start while in COLLECT or WRITE.
REQ-021 SHALL drive ByteReady=1 only in COLLECT; a byte is accepted on a clock with ByteValid && ByteReady.
REQ-022 SHALL assemble each word little-endian: the 1st accepted byte goes to WriteData[7:0], the 2nd to [15:8], the 3rd to [23:16] and the 4th to [31:24].
REQ-023 SHALL enter WRITE on the cycle after the 4th byte is accepted; no byte is accepted in WRITE.
REQ-024 SHALL, in WRITE, assert MemWrite for exactly one cycle, with Address and WriteData stable for the full cycle.
REQ-025 SHALL, on leaving WRITE, increment Address by 4, decrement the remaining word count, and clear the byte count.
REQ-026 SHALL go from WRITE to COLLECT if the remaining count is nonzero, and to DONE otherwise.
REQ-027 SHALL set Busy=1 in COLLECT and WRITE, and Busy=0 otherwise.
REQ-028 SHALL, in DONE, hold Done=1 until the next accepted Start or until reset.
REQ-029 SHALL make Abort take effect in COLLECT or WRITE: next state IDLE, Error=1, and no MemWrite in that cycle or any later cycle of the load.
REQ-030 SHALL ignore Abort in IDLE and DONE.
REQ-031 SHALL give Abort priority if it coincides with a byte acceptance or with the WRITE cycle.
REQ-032 SHALL keep Address[1:0]=0 and all Address bits above clog2(MEMORY_DEPTH)+2 at 0, so that a memory indexing by Address>>2 sees words 0..Length-1.
REQ-033 SHALL keep Address from wrapping: the maximum written Address is 4*(MEMORY_DEPTH-1).
REQ-034 SHALL hold the state when ByteValid is low in COLLECT (stall), with no timeout.

Reset
REQ-035 SHALL, on reset low, immediately (asynchronously) enter IDLE, with Address=0, WriteData=0, MemWrite=0, ByteReady=0, Busy=0, Done=0 and Error=0.
REQ-036 SHALL, on reset mid-load, leave any word not yet strobed unwritten; a later load restarts at Address 0.

Structure
REQ-037 SHALL place the state encoding (IDLE, COLLECT, WRITE, DONE) and BYTES_PER_WORD=4 as constants in a shared definitions package/include.
REQ-038 SHALL be a single module; the byte-assembly shift register MAY be split out as submodule word_assembler (ByteIn, lane select, load, clear -> word).
REQ-039 SHALL register all outputs or decode them from registered state only; no combinational path from inputs to outputs except ByteReady, which is state-only.

Verification
REQ-040 SHALL cover a nominal load: Start with Length=2, bytes 13 00 08 20 then 00 00 00 00 -> MemWrite at Address 0x0 with WriteData 0x20080013, then at 0x4 with 0x00000000; then Done=1 and Busy=0.
REQ-041 SHALL cover a full-depth load: Length=32 -> 32 strobes, the last at Address 0x7C, and Address never exceeds 0x7C.
REQ-042 SHALL cover rejected requests: Length=0 and Length=33 -> Error=1, MemWrite never asserted, Busy=0.
REQ-043 SHALL cover stall and abort: ByteValid gaps of 5 cycles mid-word -> the same words are written; Abort after the 3rd byte of word 1 -> no strobe for word 1, Error=1, IDLE.
REQ-044 SHALL cover a mid-load event: reset low after the 6th byte -> outputs at reset values immediately; a re-load with Length=1 writes Address 0x0.
REQ-045 SHALL cover Start issued during COLLECT -> ignored; the load completes with the original Length.
